// File: rtl/mux3_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux3_rr_sched_pkg
// Shared definitions for the round-robin 3:1 mux scheduler:
//   WIDTH_DEFAULT  default data width of requester ports and out_data
//   SEL_IN0/1/2    mux select encodings (2'b11 is never driven)
//   state_e        scheduler FSM states {IDLE, LOCK}
//   rrPick         round-robin pick of the next requester
//   selToGrant     select code to one-hot grant vector
// -----------------------------------------------------------------------------
package mux3_rr_sched_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic [1:0] SEL_IN0 = 2'b00;
    localparam logic [1:0] SEL_IN1 = 2'b01;
    localparam logic [1:0] SEL_IN2 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Candidates are visited in the order ptr+1, ptr+2, ptr (mod 3).  The loop
    // runs from the lowest priority offset upward so the highest priority
    // valid candidate is the last one written and therefore wins.
    function automatic logic [1:0] rrPick(input logic [1:0] ptr,
                                          input logic [2:0] valid);
        logic [1:0] idx;
        rrPick = ptr;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(ptr) + k) % 3);
            if (valid[idx]) begin
                rrPick = idx;
            end
        end
    endfunction

    function automatic logic [2:0] selToGrant(input logic [1:0] sel);
        case (sel)
            SEL_IN0: selToGrant = 3'b001;
            SEL_IN1: selToGrant = 3'b010;
            SEL_IN2: selToGrant = 3'b100;
            default: selToGrant = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mux3_rr_sched_mux3.sv
// -----------------------------------------------------------------------------
// mux3
// Plain combinational 3:1 multiplexer of WIDTH-bit words.
// Ports:
//   data_i  in  3*WIDTH  packed inputs {in2, in1, in0}
//   sel_i   in  2        SEL_IN0 / SEL_IN1 / SEL_IN2; 2'b11 yields zero
//   data_o  out WIDTH    selected word
// -----------------------------------------------------------------------------
module mux3
    import mux3_rr_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [3*WIDTH-1:0] data_i,
    input  logic [1:0]         sel_i,
    output logic [WIDTH-1:0]   data_o
);

    // The unused code 2'b11 returns zero so nothing stale can leak out.
    always_comb begin
        data_o = '0;
        case (sel_i)
            SEL_IN0: data_o = data_i[0*WIDTH +: WIDTH];
            SEL_IN1: data_o = data_i[1*WIDTH +: WIDTH];
            SEL_IN2: data_o = data_i[2*WIDTH +: WIDTH];
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mux3_rr_sched.sv
// -----------------------------------------------------------------------------
// mux3_rr_sched
// Round-robin scheduler that shares one 3:1 mux among three burst requesters.
// A requester is granted in IDLE and keeps the grant until its last beat has
// been forwarded.  Beats land in a one-deep output register with a
// valid/ready handshake toward a single consumer.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req_valid  in   3      per-requester beat valid
//   req_last   in   3      per-requester last-beat flag
//   req_data0  in   WIDTH  requester 0 data
//   req_data1  in   WIDTH  requester 1 data
//   req_data2  in   WIDTH  requester 2 data
//   req_ready  out  3      ready toward the granted requester only
//   grant      out  3      one-hot owner, 3'b000 when idle
//   sel        out  2      mux select driven to the shared mux
//   out_valid  out  1      output register holds a beat
//   out_last   out  1      last flag of the held beat
//   out_data   out  WIDTH  held beat
//   out_ready  in   1      consumer accepts the held beat
// -----------------------------------------------------------------------------
module mux3_rr_sched
    import mux3_rr_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req_valid,
    input  logic [2:0]       req_last,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    output logic [2:0]       req_ready,
    output logic [2:0]       grant,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic             out_last,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    state_e           state_q,    state_d;
    logic [2:0]       grant_q,    grant_d;
    logic [1:0]       sel_q,      sel_d;
    logic [1:0]       ptr_q,      ptr_d;
    logic             outValid_q, outValid_d;
    logic             outLast_q,  outLast_d;
    logic [WIDTH-1:0] outData_q,  outData_d;

    logic             slotFree;
    logic             beatXfer;
    logic             beatLast;
    logic [WIDTH-1:0] muxData;

    mux3 #(
        .WIDTH (WIDTH)
    ) u_mux3 (
        .data_i ({req_data2, req_data1, req_data0}),
        .sel_i  (sel_q),
        .data_o (muxData)
    );

    // The output slot can take a beat when empty or when it drains this cycle.
    // Masking with grant_q keeps every non-granted ready bit at zero, and
    // grant_q is already zero in IDLE.
    always_comb begin
        slotFree  = !outValid_q || out_ready;
        req_ready = (state_q == LOCK) ? (grant_q & {3{slotFree}}) : 3'b000;
        beatXfer  = |(req_valid & req_ready);
        beatLast  = |(req_last & grant_q);
    end

    // Arbitration happens only in IDLE; in LOCK the owner is held until its
    // last beat transfers, after which the pointer remembers it so it drops to
    // lowest priority on the next round.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outData_d  = outData_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    sel_d   = rrPick(ptr_q, req_valid);
                    grant_d = selToGrant(sel_d);
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (beatXfer && beatLast) begin
                    ptr_d   = sel_q;
                    grant_d = 3'b000;
                    sel_d   = SEL_IN0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load wins over a drain so back-to-back beats keep out_valid high.
        if (beatXfer) begin
            outValid_d = 1'b1;
            outLast_d  = beatLast;
            outData_d  = muxData;
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Pointer resets to 2 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 3'b000;
            sel_q      <= SEL_IN0;
            ptr_q      <= 2'd2;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            outData_q  <= outData_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign out_data  = outData_q;

endmodule
